stream_delay_queue: RTL and testbench
=====================================

// Module: stream_delay_queue
// PURPOSE
// - Parametrised stream delay element with a buffer of Depth beats. Each beat gets its own
//   release delay, so several delayed beats are in flight at once and delays overlap.
// - Delay per beat is either fixed (runtime value) or pseudo-random (LFSR & mask).
// - Output order equals input order. Sits between a testbench/IP stream source and sink
//   to model interconnect latency and back-pressure at full throughput.
// PARAMETERS
// - payload_t   logic      type of the payload, carried unmodified
// - Depth       4          number of buffer entries (>=1, any value, not only power of 2)
// - DelayWidth  4          width of the delay value and of the per-entry counters (1..16)
// - LfsrSeed    16'hACE1   LFSR reset value; must be non-zero
// PORTS
// - clk_i          in   1             clock
// - rst_ni         in   1             asynchronous reset, active-low
// - flush_i        in   1             synchronous drop of all buffered beats
// - rand_en_i      in   1             1: random delay, 0: fixed delay
// - fixed_delay_i  in   DelayWidth    delay used when rand_en_i=0
// - rand_mask_i    in   DelayWidth    mask applied to the LFSR when rand_en_i=1
// - payload_i      in   $bits(payload_t)  input payload
// - valid_i        in   1             input valid
// - ready_o        out  1             input ready
// - payload_o      out  $bits(payload_t)  output payload, taken from the head entry
// - valid_o        out  1             output valid
// - ready_i        in   1             output ready
// - usage_o        out  $clog2(Depth+1)   number of occupied entries
// BEHAVIOUR
// - Reset: the buffer is empty, pointers are 0, all counters are 0, and the LFSR equals LfsrSeed.
//   Output reset values: valid_o=0, ready_o=1, usage_o=0, payload_o='0.
// - Push: a beat is pushed when valid_i && ready_o. ready_o = (usage != Depth).
//   ready_o never depends on ready_i, so there is no combinational ready path.
// - Delay d per beat is sampled at push only:
//   - fixed mode: d = fixed_delay_i
//   - random mode: d = lfsr[DelayWidth-1:0] & rand_mask_i
//   - Later changes to the config inputs do not affect beats already buffered.
// - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances once per push, in both modes.
// - Counters: at push the entry counter is loaded with d. Every cycle, each occupied entry
//   with a non-zero counter decrements by 1; it saturates at 0 and never wraps.
// - Latency: a beat pushed at edge t, with a free path ahead of it, shows valid_o in the
//   cycle after edge t+d. Minimum latency is 1 cycle, because the input is never passed through.
// - Output: valid_o = !empty && (head counter == 0). payload_o = head payload.
//   - Once valid_o is high, valid_o and payload_o stay stable until ready_i is seen (AXI rule).
//   - A beat whose delay has expired but that sits behind the head waits. Order is kept.
// - Pop: a beat is popped on valid_o && ready_i.
//   - Push and pop in the same cycle leave usage unchanged.
//   - When full, a pop frees a slot from the next cycle on, not in the same cycle.
// - Pointers: read and write pointers wrap from Depth-1 to 0.
//   usage_o = occupied count, range 0..Depth.
// - flush_i: all entries are invalidated at the next edge and usage becomes 0.
//   - A push or pop in the same cycle is discarded.
//   - valid_o may still be high in the flush cycle; a handshake in that cycle counts as a
//     real transfer, and the entry is then removed by the flush.
//   - The LFSR is not reseeded by flush.
// - Reset during operation: all buffered beats are lost; state returns to the reset values above.
// - Assertions:
//   - DelayWidth is in 1..16, Depth >= 1, LfsrSeed != 0
//   - no push when full, no pop when empty
//   - valid_o/payload_o stable while (valid_o && !ready_i)
// TESTING
// - Fixed delay, fixed_delay_i=0, ready_i=1, continuous valid_i: 1 beat/cycle throughput and
//   1-cycle latency; beats 0..15 leave in order.
// - Fixed delay 3, Depth=4, ready_i=1, back-to-back beats A,B,C: valid_o for A, B, C in the
//   cycles after edges t+3, t+4, t+5, so the delays overlap.
// - ready_i=0, push 5 beats into Depth=4: ready_o drops after 4 pushes and usage_o=4.
//   Raise ready_i: beats pop 1/cycle, and ready_o returns the cycle after the first pop.
// - Random mode, mask=4'hF, LfsrSeed=16'hACE1: the per-beat delay sequence matches the
//   reference LFSR model. A beat with d=7 behind a beat with d=2 holds order.
//   A mask of 0 gives latency 1.
// - flush_i pulsed with 3 beats buffered and simultaneous valid_i: usage_o=0 and valid_o=0
//   on the next cycle, and the pushed beat is dropped.
// - rst_ni asserted mid-stream with usage_o=2: valid_o=0, ready_o=1, usage_o=0 immediately.
//   After release, the first random delay equals that of a fresh seed.

Source files
------------

// File: rtl/stream_delay_queue.sv
`default_nettype none
// ============================================================================
// Module      : stream_delay_queue
// Description : Stream delay element. Holds up to Depth beats. Each beat gets
//               its own release delay, loaded into a per-entry down-counter at
//               push time. The delays of beats in flight therefore overlap.
//               The head beat is offered when its counter reaches zero. Beats
//               leave in the order they arrived. A delay is either a runtime
//               fixed value or a 16-bit Galois LFSR value ANDed with a mask.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   payload_t   payload type, carried unmodified
//   Depth       number of buffer entries (>= 1, any value)
//   DelayWidth  width of the delay value and of the entry counters (1..16)
//   LfsrSeed    LFSR reset value (non-zero)
// Ports
//   clk_i          clock
//   rst_ni         asynchronous reset, active-low
//   flush_i        synchronous drop of all buffered beats
//   rand_en_i      1: LFSR-based delay, 0: fixed_delay_i
//   fixed_delay_i  delay used in fixed mode
//   rand_mask_i    mask applied to the LFSR in random mode
//   payload_i      input payload
//   valid_i        input valid
//   ready_o        input ready (depends only on the fill level)
//   payload_o      output payload (head entry)
//   valid_o        output valid
//   ready_i        output ready
//   usage_o        number of occupied entries (0..Depth)
// ============================================================================
module stream_delay_queue #(
    parameter type         payload_t  = logic,
    parameter int unsigned Depth      = 4,
    parameter int unsigned DelayWidth = 4,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       rand_en_i,
    input  logic [DelayWidth-1:0]      fixed_delay_i,
    input  logic [DelayWidth-1:0]      rand_mask_i,
    input  payload_t                   payload_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output payload_t                   payload_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_PTR_W   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_USAGE_W = $clog2(Depth + 1);
    localparam logic [c_PTR_W-1:0]   c_LAST_PTR = c_PTR_W'(Depth - 1);
    localparam logic [c_USAGE_W-1:0] c_FULL     = c_USAGE_W'(Depth);
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11.
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_USAGE_W-1:0]  r_usage;
    logic [15:0]           r_lfsr;
    payload_t              r_payload [Depth];
    logic [DelayWidth-1:0] r_cnt     [Depth];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_pop_eff;
    logic [DelayWidth-1:0] w_delay;
    logic [15:0]           w_lfsr_next;
    logic [c_PTR_W-1:0]    w_wr_ptr_next;
    logic [c_PTR_W-1:0]    w_rd_ptr_next;

    assign w_full  = (r_usage == c_FULL);
    assign w_empty = (r_usage == '0);

    // ready_o is a pure function of the fill level; a slot freed by a pop
    // becomes visible one cycle later, which keeps ready_i out of this path.
    assign ready_o = !w_full;

    // Only an occupied head whose counter has run out is offered. The
    // counter cannot rise again while the beat sits at the head, so valid_o
    // and payload_o hold until the beat is taken (or flushed).
    assign valid_o   = !w_empty && (r_cnt[r_rd_ptr] == '0);
    assign payload_o = r_payload[r_rd_ptr];
    assign usage_o   = r_usage;

    // A push coinciding with flush is dropped and does not count as a push,
    // so it neither stores a beat nor advances the LFSR. A pop in the flush
    // cycle is a real transfer for the sink; the flush clears the buffer.
    assign w_push    = valid_i && ready_o && !flush_i;
    assign w_pop     = valid_o && ready_i;
    assign w_pop_eff = w_pop && !flush_i;

    // Delay is captured only at push; later config changes leave stored
    // beats untouched.
    assign w_delay = rand_en_i ? (r_lfsr[DelayWidth-1:0] & rand_mask_i)
                               : fixed_delay_i;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);

    // Explicit wrap so non-power-of-two depths work.
    assign w_wr_ptr_next = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr_next = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);

    // ------------------------------------------------------------------------
    // Pointers, fill level and LFSR
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usage  <= '0;
            r_lfsr   <= LfsrSeed;
        end else begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_usage  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= w_wr_ptr_next;
                end
                if (w_pop_eff) begin
                    r_rd_ptr <= w_rd_ptr_next;
                end
                case ({w_push, w_pop_eff})
                    2'b10:   r_usage <= r_usage + c_USAGE_W'(1);
                    2'b01:   r_usage <= r_usage - c_USAGE_W'(1);
                    default: r_usage <= r_usage;
                endcase
            end
            // The LFSR is not reseeded by flush; it moves once per push.
            if (w_push) begin
                r_lfsr <= w_lfsr_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-entry payload storage and release counters
    // ------------------------------------------------------------------------
    // Every entry with a non-zero counter counts down each cycle, whether or
    // not it is at the head, so delays of queued beats run concurrently.
    // Free entries always hold 0 (cleared by reset/flush, or already expired
    // when popped), so counting them down is harmless.
    for (genvar i = 0; i < int'(Depth); i++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_payload[i] <= '0;
                r_cnt[i]     <= '0;
            end else if (flush_i) begin
                r_cnt[i]     <= '0;
            end else if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
                r_payload[i] <= payload_i;
                r_cnt[i]     <= w_delay;
            end else if (r_cnt[i] != '0) begin
                r_cnt[i]     <= r_cnt[i] - DelayWidth'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    localparam bit c_PARAMS_OK = (DelayWidth >= 1) && (DelayWidth <= 16) &&
                                 (Depth >= 1) && (LfsrSeed != 16'h0000);

    a_params_ok : assert property (@(posedge clk_i) c_PARAMS_OK)
        else $error("stream_delay_queue: illegal parameter set");

    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_push |-> !w_full)
        else $error("stream_delay_queue: push while full");

    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_pop |-> !w_empty)
        else $error("stream_delay_queue: pop while empty");

    a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(payload_o)))
        else $error("stream_delay_queue: output changed while stalled");
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_delay_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_delay_queue
// Description : Self-checking bench for stream_delay_queue (Depth=4,
//               DelayWidth=4, 16-bit payload). A reference model keeps a
//               queue of beats tagged with push cycle and delay; a head beat
//               is due once the current cycle reaches push cycle + delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_delay_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef logic [15:0] pl_t;
    typedef struct {
        pl_t pl;
        int  t;
        int  d;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          rand_en_i = 1'b0;
    logic [DW-1:0] fixed_delay_i = '0;
    logic [DW-1:0] rand_mask_i = '0;
    pl_t           payload_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    pl_t           payload_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [2:0]    usage_o;

    stream_delay_queue #(
        .payload_t  (pl_t),
        .Depth      (DEPTH),
        .DelayWidth (DW),
        .LfsrSeed   (SEED)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .rand_en_i     (rand_en_i),
        .fixed_delay_i (fixed_delay_i),
        .rand_mask_i   (rand_mask_i),
        .payload_i     (payload_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .payload_o     (payload_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .usage_o       (usage_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    beat_t       mq[$];
    int          n = 0;          // index of the most recent clock edge
    logic [15:0] m_lfsr = SEED;
    pl_t         dut_log[$];     // DUT payload seen at each transfer
    int          dut_cyc[$];     // edge at which each transfer happened
    int          tests = 0;
    int          fails = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic m_valid();
        return (mq.size() > 0) && (n >= mq[0].t + mq[0].d);
    endfunction

    function automatic logic m_ready();
        return mq.size() != DEPTH;
    endfunction

    function automatic logic [20:0] exp_vec();
        pl_t p;
        p = m_valid() ? mq[0].pl : 16'h0000;
        return {m_valid(), m_ready(), 3'(mq.size()), p};
    endfunction

    function automatic logic [20:0] got_vec();
        pl_t p;
        p = valid_o ? payload_o : 16'h0000;
        return {valid_o, ready_o, usage_o, p};
    endfunction

    // Advance one clock; model follows its own handshake view.
    task automatic step();
        logic push, pop;
        int   d;
        push = valid_i && m_ready() && !flush_i;
        pop  = m_valid() && ready_i;
        d    = rand_en_i ? int'(m_lfsr[DW-1:0] & rand_mask_i) : int'(fixed_delay_i);
        if (pop) begin
            dut_log.push_back(payload_o);
            dut_cyc.push_back(n + 1);
        end
        @(posedge clk_i);
        #1;
        n++;
        if (flush_i) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{payload_i, n, d});
        end
        if (push) m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        rst_ni  = 1'b0;
        @(posedge clk_i);
        #1;
        n++;
        rst_ni = 1'b1;
        mq.delete();
        dut_log.delete();
        dut_cyc.delete();
        m_lfsr = SEED;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        tests++; if (usage_o !== 3'd0) begin fails++; $display("FAIL reset_usage: got %0d expected 0", usage_o); end
        tests++; if (payload_o !== 16'h0) begin fails++; $display("FAIL reset_payload: got %h expected 0000", payload_o); end
    endtask

    task automatic test_zero_delay_stream();
        int t0;
        do_reset();
        rand_en_i = 1'b0;
        fixed_delay_i = '0;
        ready_i = 1'b1;
        t0 = n + 1;
        for (int i = 0; i < 19; i++) begin
            valid_i   = (i < 16);
            payload_i = pl_t'(i);
            step();
            tests++;
            if (got_vec() !== exp_vec()) begin
                fails++; $display("FAIL zero_delay_cycle %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        tests++; if (dut_log.size() != 16) begin fails++; $display("FAIL zero_delay_count: got %0d expected 16", dut_log.size()); end
        for (int i = 0; i < dut_log.size() && i < 16; i++) begin
            tests++;
            if (dut_log[i] !== pl_t'(i) || dut_cyc[i] != t0 + 1 + i) begin
                fails++; $display("FAIL zero_delay_beat %0d: got %h at edge %0d expected %h at edge %0d",
                                  i, dut_log[i], dut_cyc[i], i, t0 + 1 + i);
            end
        end
    endtask

    task automatic test_overlap();
        int  t0;
        logic ev;
        do_reset();
        rand_en_i = 1'b0;
        fixed_delay_i = 4'd3;
        ready_i = 1'b1;
        t0 = n + 1;
        for (int k = 0; k < 9; k++) begin
            valid_i   = (k < 3);
            payload_i = 16'h00A0 + pl_t'(k);
            step();
            ev = (n - t0 >= 3) && (n - t0 <= 5);
            tests++;
            if (valid_o !== ev || got_vec() !== exp_vec()) begin
                fails++; $display("FAIL overlap_edge t+%0d: got %h expected valid %b model %h", n - t0, got_vec(), ev, exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rand_en_i = 1'b0;
        fixed_delay_i = '0;
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            payload_i = pl_t'(16'h0B00 + k);
            step();
            tests++;
            if (usage_o !== 3'((k < 4) ? k + 1 : 4) || ready_o !== (k < 3)) begin
                fails++; $display("FAIL bp_fill %0d: got usage %0d ready %b expected usage %0d ready %b",
                                  k, usage_o, ready_o, (k < 4) ? k + 1 : 4, (k < 3));
            end
        end
        ready_i = 1'b1;
        step();
        tests++;
        if (ready_o !== 1'b1 || usage_o !== 3'd3) begin
            fails++; $display("FAIL bp_first_pop: got ready %b usage %0d expected ready 1 usage 3", ready_o, usage_o);
        end
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            tests++;
            if (got_vec() !== exp_vec()) begin
                fails++; $display("FAIL bp_drain %0d: got %h expected %h", k, got_vec(), exp_vec());
            end
        end
        tests++; if (dut_log.size() != 5) begin fails++; $display("FAIL bp_count: got %0d expected 5", dut_log.size()); end
        for (int i = 0; i < dut_log.size() && i < 5; i++) begin
            tests++;
            if (dut_log[i] !== pl_t'(16'h0B00 + i)) begin
                fails++; $display("FAIL bp_order %0d: got %h expected %h", i, dut_log[i], 16'h0B00 + i);
            end
            if (i > 0) begin
                tests++;
                if (dut_cyc[i] != dut_cyc[i-1] + 1) begin
                    fails++; $display("FAIL bp_rate %0d: got edge %0d expected %0d", i, dut_cyc[i], dut_cyc[i-1] + 1);
                end
            end
        end
    endtask

    task automatic test_order_and_mask();
        int dl[2][2] = '{'{7, 2}, '{2, 7}};
        for (int s = 0; s < 2; s++) begin
            do_reset();
            rand_en_i = 1'b0;
            ready_i = 1'b1;
            for (int k = 0; k < 14; k++) begin
                valid_i = (k < 2);
                fixed_delay_i = DW'((k < 2) ? dl[s][k] : 15);
                payload_i = 16'h0C00 + pl_t'(s * 16 + k);
                step();
                tests++;
                if (got_vec() !== exp_vec()) begin
                    fails++; $display("FAIL order_set%0d_cycle %0d: got %h expected %h", s, k, got_vec(), exp_vec());
                end
            end
            tests++;
            if (dut_log.size() != 2 || dut_log[0] !== 16'h0C00 + pl_t'(s * 16) || dut_log[1] !== 16'h0C01 + pl_t'(s * 16)) begin
                fails++; $display("FAIL order_set%0d: got %0d beats expected 2 in push order", s, dut_log.size());
            end
        end
        do_reset();
        rand_en_i = 1'b1;
        rand_mask_i = '0;
        ready_i = 1'b0;
        valid_i = 1'b1;
        payload_i = 16'h0D00;
        step();
        valid_i = 1'b0;
        tests++;
        if (valid_o !== 1'b1 || payload_o !== 16'h0D00) begin
            fails++; $display("FAIL mask0_latency: got valid %b payload %h expected 1 0D00", valid_o, payload_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            valid_i = ($urandom_range(0, 9) < 6);
            ready_i = ($urandom_range(0, 9) < 7);
            payload_i = pl_t'($urandom);
            if ($urandom_range(0, 15) == 0) rand_en_i = ~rand_en_i;
            if ($urandom_range(0, 7) == 0) fixed_delay_i = DW'($urandom);
            rand_mask_i = (k < 200) ? 4'hF : DW'($urandom);
            step();
            tests++;
            if (got_vec() !== exp_vec()) begin
                fails++; $display("FAIL random_cycle %0d: got %h expected %h", k, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        rand_en_i = 1'b0;
        fixed_delay_i = '0;
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            payload_i = 16'h0E00 + pl_t'(k);
            step();
        end
        tests++; if (usage_o !== 3'd3) begin fails++; $display("FAIL flush_prefill: got %0d expected 3", usage_o); end
        flush_i = 1'b1;
        ready_i = 1'b1;
        payload_i = 16'h0EFF;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        tests++;
        if (usage_o !== 3'd0 || valid_o !== 1'b0) begin
            fails++; $display("FAIL flush_clear: got usage %0d valid %b expected 0 0", usage_o, valid_o);
        end
        tests++;
        if (dut_log.size() != 1 || dut_log[0] !== 16'h0E00) begin
            fails++; $display("FAIL flush_transfer: got %0d beats expected 1 (0E00)", dut_log.size());
        end
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (valid_o !== 1'b0 || usage_o !== 3'd0) begin
                fails++; $display("FAIL flush_dropped %0d: got valid %b usage %0d expected 0 0", k, valid_o, usage_o);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        rand_en_i = 1'b0;
        fixed_delay_i = 4'd9;
        ready_i = 1'b0;
        valid_i = 1'b1;
        step();
        step();
        valid_i = 1'b0;
        tests++; if (usage_o !== 3'd2) begin fails++; $display("FAIL midrst_prefill: got %0d expected 2", usage_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || usage_o !== 3'd0) begin
            fails++; $display("FAIL midrst_async: got valid %b ready %b usage %0d expected 0 1 0", valid_o, ready_o, usage_o);
        end
        @(posedge clk_i);
        #1;
        n++;
        rst_ni = 1'b1;
        mq.delete();
        dut_log.delete();
        dut_cyc.delete();
        m_lfsr = SEED;
        // Fresh seed 16'hACE1 with mask F gives a first delay of 1.
        rand_en_i = 1'b1;
        rand_mask_i = 4'hF;
        valid_i = 1'b1;
        payload_i = 16'h0F00;
        step();
        valid_i = 1'b0;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL midrst_seed_early: got %b expected 0", valid_o); end
        step();
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL midrst_seed_due: got %b expected 1", valid_o); end
    endtask

    initial begin
        test_reset();
        test_zero_delay_stream();
        test_overlap();
        test_backpressure();
        test_order_and_mask();
        test_random();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
